// File: rtl/keccak_round_ctrl.sv
// ============================================================================
// keccak_round_ctrl
//   Sequences the rounds of one Keccak-f permutation and generates each
//   round's iota constant bit-serially from the 8-bit rc LFSR.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module keccak_round_ctrl #(
  parameter int NUM_ROUNDS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        perm_start,
  input  logic        perm_abort,
  input  logic        step_valid,
  output logic        step_start,
  output logic [4:0]  round,
  output logic [63:0] rc,
  output logic        perm_busy,
  output logic        perm_done
);

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_lfsr;
  logic [2:0]  r_bitcnt;
  logic [8:0]  w_shift;
  logic [6:0]  w_pow;
  logic [6:0]  w_pos;

  // Polynomial x^8+x^6+x^5+x^4+1: fold the carried-out bit back into 0,4,5,6.
  always_comb begin
    w_shift = {r_lfsr, 1'b0};
    if (w_shift[8]) begin
      w_shift = w_shift ^ 9'h171;
    end
  end

  // GEN cycle j writes rc bit 2^j-1.
  assign w_pow = 7'd1 << r_bitcnt;
  assign w_pos = w_pow - 7'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_lfsr     <= 8'h01;
      r_bitcnt   <= 3'd0;
      round      <= 5'd0;
      rc         <= 64'd0;
      step_start <= 1'b0;
      perm_done  <= 1'b0;
      perm_busy  <= 1'b0;
    end else begin
      step_start <= 1'b0;
      perm_done  <= 1'b0;
      if (r_state != IDLE && perm_abort) begin
        r_state   <= IDLE;
        perm_busy <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (perm_start) begin
              r_state   <= GEN;
              r_lfsr    <= 8'h01;
              r_bitcnt  <= 3'd0;
              round     <= 5'd0;
              rc        <= 64'd0;
              perm_busy <= 1'b1;
            end
          end
          GEN: begin
            rc[w_pos[5:0]] <= r_lfsr[0];
            r_lfsr         <= w_shift[7:0];
            if (r_bitcnt == 3'd6) begin
              r_bitcnt   <= 3'd0;
              r_state    <= ISSUE;
              step_start <= 1'b1;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
          ISSUE: begin
            r_state <= WAIT;
          end
          WAIT: begin
            if (step_valid) begin
              if (round == LAST_ROUND) begin
                r_state   <= DONE;
                perm_done <= 1'b1;
              end else begin
                round   <= round + 5'd1;
                rc      <= 64'd0;
                r_state <= GEN;
              end
            end
          end
          DONE: begin
            r_state   <= IDLE;
            perm_busy <= 1'b0;
          end
          default: begin
            r_state   <= IDLE;
            perm_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
